// File: rtl/ip_codma_bus_master.sv
// ip_codma_bus_master: round-robin multi-channel front end and single driver
// of the shared codma bus. It runs one request/grant/burst transaction at a time.
//
// Parameters:
//   NUM_CH          number of requesting channels (1..8)
//   DATA_W          bus data width in bits (multiple of 32)
//   ADDR_W          address width
//   MAX_BEATS       largest legal burst, in beats
//   TIMEOUT_CYCLES  limit on the wait for a grant
//
// Ports:
//   clk_i, reset_i         clock and synchronous active-high reset
//   ch_req_i/we/addr/size  per-channel request, sampled at arbitration
//   ch_abort_i             per-channel stop request
//   ch_wdata_i             current write beat of each channel
//   ch_wdata_ready_o       write beat consumed this cycle
//   ch_rdata_o             shared read beat
//   ch_rdata_valid_o       read beat valid, per channel
//   ch_done_o/ch_error_o   one-cycle completion and error pulses
//   busy_o                 high whenever the FSM is not idle
//   bus_*                  shared bus request, grant and data phase
//
// Optional feature: when the macro CODMA_BUS_TIMEOUT_EN is defined, a wait
// in ASK that lasts TIMEOUT_CYCLES cycles without a grant ends in ERROR.
module ip_codma_bus_master #(
  parameter int NUM_CH         = 2,
  parameter int DATA_W         = 64,
  parameter int ADDR_W         = 32,
  parameter int MAX_BEATS      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        ch_req_i,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*8-1:0]      ch_size_i,
  input  logic [NUM_CH-1:0]        ch_abort_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]        ch_wdata_ready_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [NUM_CH-1:0]        ch_rdata_valid_o,
  output logic [NUM_CH-1:0]        ch_done_o,
  output logic [NUM_CH-1:0]        ch_error_o,
  output logic                     busy_o,
  output logic                     bus_read_o,
  output logic                     bus_write_o,
  output logic [ADDR_W-1:0]        bus_addr_o,
  output logic [7:0]               bus_size_o,
  output logic                     bus_write_valid_o,
  output logic [DATA_W-1:0]        bus_write_data_o,
  input  logic                     bus_grant_i,
  input  logic                     bus_ready_i,
  input  logic                     bus_read_valid_i,
  input  logic                     bus_error_i,
  input  logic [DATA_W-1:0]        bus_read_data_i
);

  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW  = $clog2(MAX_BEATS + 1);
  localparam int BPB = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    ASK,
    GRANTED,
    DONE,
    ERROR
  } state_t;

  state_t          state;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   last_ch;
  logic            we_q;
  logic            abort_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]      size_q;
  logic [CW-1:0]   cnt;

`ifdef CODMA_BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]   tmo;
`endif

  // Beats needed for a byte count; a partial last beat counts as one beat.
  function automatic int beats_of(input logic [7:0] s);
    return (int'(s) + BPB - 1) / BPB;
  endfunction

  // Round-robin: the first requester after last_ch, wrapping around.
  logic [SW-1:0] arb_ch;
  logic          arb_hit;
  int            idx;

  always_comb begin
    arb_ch  = '0;
    arb_hit = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_ch) + i) % NUM_CH;
      if (!arb_hit && ch_req_i[idx]) begin
        arb_hit = 1'b1;
        arb_ch  = SW'(idx);
      end
    end
  end

  logic [7:0] req_size;
  assign req_size = ch_size_i[int'(arb_ch)*8 +: 8];

  logic beat;
  assign beat = we_q ? bus_ready_i : bus_read_valid_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= IDLE;
      sel     <= '0;
      last_ch <= SW'(NUM_CH - 1);
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      cnt     <= '0;
`ifdef CODMA_BUS_TIMEOUT_EN
      tmo     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          abort_q <= 1'b0;
          cnt     <= '0;
`ifdef CODMA_BUS_TIMEOUT_EN
          tmo     <= '0;
`endif
          if (arb_hit) begin
            sel    <= arb_ch;
            we_q   <= ch_we_i[arb_ch];
            addr_q <= ch_addr_i[int'(arb_ch)*ADDR_W +: ADDR_W];
            size_q <= req_size;
            // Illegal sizes are rejected before any bus activity.
            if (req_size == 8'd0 || beats_of(req_size) > MAX_BEATS)
              state <= ERROR;
            else
              state <= ASK;
          end
        end
        ASK: begin
          // An abort beats a same-cycle grant: no data phase follows.
          if (ch_abort_i[sel] || bus_error_i) begin
            state <= ERROR;
          end else if (bus_grant_i) begin
            state <= GRANTED;
            cnt   <= CW'(beats_of(size_q));
          end
`ifdef CODMA_BUS_TIMEOUT_EN
          else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
            state <= ERROR;
          end else begin
            tmo <= tmo + 1'b1;
          end
`endif
        end
        GRANTED: begin
          // A granted burst always runs to the end; abort only
          // changes how it is reported.
          abort_q <= abort_q | ch_abort_i[sel];
          if (bus_error_i) begin
            state <= ERROR;
          end else if (beat) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1))
              state <= (abort_q || ch_abort_i[sel]) ? ERROR : DONE;
          end
        end
        DONE, ERROR: begin
          last_ch <= sel;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [NUM_CH-1:0] sel_oh;
  logic              in_ask;
  logic              in_gnt;
  logic              on_bus;

  assign sel_oh = NUM_CH'(1) << sel;
  assign in_ask = (state == ASK);
  assign in_gnt = (state == GRANTED);
  assign on_bus = in_ask || in_gnt;

  assign busy_o            = (state != IDLE);
  assign bus_read_o        = in_ask && !we_q;
  assign bus_write_o       = in_ask && we_q;
  assign bus_addr_o        = on_bus ? addr_q : '0;
  assign bus_size_o        = on_bus ? size_q : '0;
  assign bus_write_valid_o = in_gnt && we_q;

  assign bus_write_data_o =
    (in_gnt && we_q) ? ch_wdata_i[int'(sel)*DATA_W +: DATA_W] : '0;

  assign ch_wdata_ready_o =
    (in_gnt && we_q && bus_ready_i) ? sel_oh : '0;

  assign ch_rdata_o = (in_gnt && !we_q) ? bus_read_data_i : '0;

  assign ch_rdata_valid_o =
    (in_gnt && !we_q && bus_read_valid_i) ? sel_oh : '0;

  assign ch_done_o  = (state == DONE)  ? sel_oh : '0;
  assign ch_error_o = (state == ERROR) ? sel_oh : '0;

endmodule

// File: tb/tb_ip_codma_bus_master.sv
// tb_ip_codma_bus_master: directed bench for the codma bus master.
// Expected values are hand-derived constants.
module tb_ip_codma_bus_master;

  localparam int NC = 2;
  localparam int DW = 64;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [NC-1:0] ch_req_i = '0;
  logic [NC-1:0] ch_we_i = '0;
  logic [NC*AW-1:0] ch_addr_i = '0;
  logic [NC*8-1:0]  ch_size_i = '0;
  logic [NC-1:0] ch_abort_i = '0;
  logic [NC*DW-1:0] ch_wdata_i = '0;
  logic [NC-1:0] ch_wdata_ready_o;
  logic [DW-1:0] ch_rdata_o;
  logic [NC-1:0] ch_rdata_valid_o;
  logic [NC-1:0] ch_done_o;
  logic [NC-1:0] ch_error_o;
  logic          busy_o;
  logic          bus_read_o;
  logic          bus_write_o;
  logic [AW-1:0] bus_addr_o;
  logic [7:0]    bus_size_o;
  logic          bus_write_valid_o;
  logic [DW-1:0] bus_write_data_o;
  logic          bus_grant_i = 1'b0;
  logic          bus_ready_i = 1'b0;
  logic          bus_read_valid_i = 1'b0;
  logic          bus_error_i = 1'b0;
  logic [DW-1:0] bus_read_data_i = '0;

  ip_codma_bus_master #(
    .NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW),
    .MAX_BEATS(8), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ch_req_i(ch_req_i), .ch_we_i(ch_we_i),
    .ch_addr_i(ch_addr_i), .ch_size_i(ch_size_i),
    .ch_abort_i(ch_abort_i), .ch_wdata_i(ch_wdata_i),
    .ch_wdata_ready_o(ch_wdata_ready_o),
    .ch_rdata_o(ch_rdata_o),
    .ch_rdata_valid_o(ch_rdata_valid_o),
    .ch_done_o(ch_done_o), .ch_error_o(ch_error_o),
    .busy_o(busy_o),
    .bus_read_o(bus_read_o), .bus_write_o(bus_write_o),
    .bus_addr_o(bus_addr_o), .bus_size_o(bus_size_o),
    .bus_write_valid_o(bus_write_valid_o),
    .bus_write_data_o(bus_write_data_o),
    .bus_grant_i(bus_grant_i), .bus_ready_i(bus_ready_i),
    .bus_read_valid_i(bus_read_valid_i),
    .bus_error_i(bus_error_i),
    .bus_read_data_i(bus_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_rv = 0;
  int cnt_wr = 0;
  int cnt_both = 0;
  int base;

  always @(negedge clk_i) begin
    if (|ch_rdata_valid_o) cnt_rv <= cnt_rv + 1;
    if (|ch_wdata_ready_o) cnt_wr <= cnt_wr + 1;
    if (bus_read_o && bus_write_o) cnt_both <= cnt_both + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (!(bus_read_o || bus_write_o) && n < 20) begin
      cyc();
      n++;
    end
    chk("strobe_wait", 64'(n < 20), 64'd1);
  endtask

  task automatic rd_txn(input int ch);
    logic [NC-1:0] oh;
    oh = NC'(1) << ch;
    wait_strobe();
    chk("t2_addr", 64'(bus_addr_o),
        (ch == 1) ? 64'h200 : 64'h100);
    bus_grant_i = 1'b1;
    cyc();
    bus_grant_i = 1'b0;
    bus_read_valid_i = 1'b1;
    #1;
    chk("t2_rvalid", 64'(ch_rdata_valid_o), 64'(oh));
    cyc();
    bus_read_valid_i = 1'b0;
    chk("t2_done", 64'(ch_done_o), 64'(oh));
    cyc();
  endtask

  initial begin
    ch_addr_i = {32'h200, 32'h100};
    cyc();
    cyc();
    reset_i = 1'b0;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rd", 64'(bus_read_o), 64'd0);
    chk("rst_addr", 64'(bus_addr_o), 64'd0);
    chk("rst_done", 64'(ch_done_o), 64'd0);

    // ch0 read, 32 bytes -> 4 beats, grant after 3 ASK cycles
    ch_req_i = 2'b01;
    ch_we_i = 2'b00;
    ch_size_i = {8'd8, 8'd32};
    cyc();
    chk("t1_rd", 64'(bus_read_o), 64'd1);
    chk("t1_wr", 64'(bus_write_o), 64'd0);
    chk("t1_addr", 64'(bus_addr_o), 64'h100);
    chk("t1_size", 64'(bus_size_o), 64'd32);
    chk("t1_busy", 64'(busy_o), 64'd1);
    cyc();
    cyc();
    chk("t1_hold", 64'(bus_read_o), 64'd1);
    bus_grant_i = 1'b1;
    cyc();
    bus_grant_i = 1'b0;
    base = cnt_rv;
    for (int b = 0; b < 4; b++) begin
      bus_read_valid_i = 1'b1;
      bus_read_data_i = 64'hD0 + 64'(b);
      #1;
      chk("t1_rdata", ch_rdata_o, 64'hD0 + 64'(b));
      chk("t1_rvalid", 64'(ch_rdata_valid_o), 64'd1);
      chk("t1_nodone", 64'(ch_done_o), 64'd0);
      cyc();
    end
    bus_read_valid_i = 1'b0;
    chk("t1_done", 64'(ch_done_o), 64'd1);
    chk("t1_beats", 64'(cnt_rv - base), 64'd4);
    ch_req_i = 2'b00;
    cyc();
    chk("t1_idle", 64'(busy_o), 64'd0);
    chk("t1_done_off", 64'(ch_done_o), 64'd0);

    // both channels requesting -> 0,1,0,1
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    ch_req_i = 2'b11;
    ch_size_i = {8'd8, 8'd8};
    for (int k = 0; k < 4; k++) rd_txn(k % 2);
    ch_req_i = 2'b00;
    cyc();
    cyc();
    chk("t2_no_both", 64'(cnt_both), 64'd0);

    // ch1 write, 12 bytes -> 2 beats, ready on alternate cycles
    ch_req_i = 2'b10;
    ch_we_i = 2'b10;
    ch_size_i = {8'd12, 8'd8};
    wait_strobe();
    chk("t3_wr", 64'(bus_write_o), 64'd1);
    chk("t3_rd", 64'(bus_read_o), 64'd0);
    chk("t3_size", 64'(bus_size_o), 64'd12);
    chk("t3_addr", 64'(bus_addr_o), 64'h200);
    bus_grant_i = 1'b1;
    cyc();
    bus_grant_i = 1'b0;
    base = cnt_wr;
    for (int c = 0; c < 4; c++) begin
      bus_ready_i = ((c % 2) == 1);
      ch_wdata_i[127:64] = 64'hAAAA0001 + 64'(c / 2);
      #1;
      chk("t3_wvalid", 64'(bus_write_valid_o), 64'd1);
      chk("t3_wdata", bus_write_data_o,
          64'hAAAA0001 + 64'(c / 2));
      chk("t3_wready", 64'(ch_wdata_ready_o),
          ((c % 2) == 1) ? 64'd2 : 64'd0);
      cyc();
    end
    bus_ready_i = 1'b0;
    chk("t3_done", 64'(ch_done_o), 64'd2);
    chk("t3_beats", 64'(cnt_wr - base), 64'd2);
    ch_req_i = 2'b00;
    ch_we_i = 2'b00;
    cyc();
    chk("t3_wvalid_off", 64'(bus_write_valid_o), 64'd0);

    // abort in ASK
    ch_req_i = 2'b01;
    wait_strobe();
    ch_abort_i = 2'b01;
    cyc();
    ch_abort_i = 2'b00;
    chk("t4_strobe_drop", 64'(bus_read_o), 64'd0);
    chk("t4_err", 64'(ch_error_o), 64'd1);
    chk("t4_nodone", 64'(ch_done_o), 64'd0);
    ch_req_i = 2'b00;
    cyc();

    // abort mid-burst: burst of 2 completes, then error
    ch_size_i = {8'd8, 8'd16};
    ch_req_i = 2'b01;
    wait_strobe();
    bus_grant_i = 1'b1;
    cyc();
    bus_grant_i = 1'b0;
    base = cnt_rv;
    bus_read_valid_i = 1'b1;
    ch_abort_i = 2'b01;
    cyc();
    ch_abort_i = 2'b00;
    chk("t4b_busy", 64'(busy_o), 64'd1);
    chk("t4b_noerr", 64'(ch_error_o), 64'd0);
    cyc();
    bus_read_valid_i = 1'b0;
    chk("t4b_err", 64'(ch_error_o), 64'd1);
    chk("t4b_nodone", 64'(ch_done_o), 64'd0);
    chk("t4b_beats", 64'(cnt_rv - base), 64'd2);
    ch_req_i = 2'b00;
    cyc();

    // size 0 and size 72 -> error without bus strobe
    ch_size_i = {8'd8, 8'd0};
    ch_req_i = 2'b01;
    cyc();
    chk("t5_sz0_err", 64'(ch_error_o), 64'd1);
    chk("t5_sz0_rd", 64'(bus_read_o), 64'd0);
    ch_req_i = 2'b00;
    cyc();
    ch_size_i = {8'd8, 8'd72};
    ch_req_i = 2'b01;
    cyc();
    chk("t5_sz72_err", 64'(ch_error_o), 64'd1);
    chk("t5_sz72_rd", 64'(bus_read_o), 64'd0);
    ch_req_i = 2'b00;
    cyc();
    chk("t5_sz72_idle", 64'(busy_o), 64'd0);

    // bus error on beat 2
    ch_size_i = {8'd8, 8'd32};
    ch_req_i = 2'b01;
    wait_strobe();
    bus_grant_i = 1'b1;
    cyc();
    bus_grant_i = 1'b0;
    bus_read_valid_i = 1'b1;
    cyc();
    bus_read_valid_i = 1'b0;
    bus_error_i = 1'b1;
    cyc();
    bus_error_i = 1'b0;
    chk("t5_buserr", 64'(ch_error_o), 64'd1);
    chk("t5_buserr_nd", 64'(ch_done_o), 64'd0);
    ch_req_i = 2'b00;
    cyc();
    chk("t5_idle", 64'(busy_o), 64'd0);

    // reset mid-burst
    ch_req_i = 2'b01;
    wait_strobe();
    bus_grant_i = 1'b1;
    cyc();
    bus_grant_i = 1'b0;
    bus_read_valid_i = 1'b1;
    bus_read_data_i = 64'h1234;
    cyc();
    reset_i = 1'b1;
    cyc();
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_rvalid", 64'(ch_rdata_valid_o), 64'd0);
    chk("t6_rdata", ch_rdata_o, 64'd0);
    chk("t6_addr", 64'(bus_addr_o), 64'd0);
    chk("t6_pulses", 64'({ch_done_o, ch_error_o}), 64'd0);
    reset_i = 1'b0;
    ch_req_i = 2'b00;
    bus_read_valid_i = 1'b0;
    cyc();

`ifdef CODMA_BUS_TIMEOUT_EN
    begin
      int n;
      n = 0;
      ch_size_i = {8'd8, 8'd8};
      ch_req_i = 2'b01;
      wait_strobe();
      while (!ch_error_o[0] && n < 30) begin
        if (bus_read_o) n++;
        cyc();
      end
      chk("tmo_cycles", 64'(n), 64'd10);
      chk("tmo_err", 64'(ch_error_o), 64'd1);
      ch_req_i = 2'b00;
      cyc();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
